// File: rtl/pic_controller.sv
// Programmable 8-line interrupt controller: latches requests, applies mask and
// in-service nesting, drives INT and returns a vector on intack.
module pic_controller #(
  parameter logic [7:0]  EDGE_MODE    = 8'hFF,
  parameter logic [15:0] SPURIOUS_VEC = 16'h0007
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  irq,
  input  logic        intack,
  output logic        INT,
  output logic [15:0] vector,
  input  logic [1:0]  reg_sel,
  input  logic        reg_wt,
  input  logic [15:0] reg_wdata,
  output logic [15:0] reg_rdata
);

  localparam logic [1:0] SEL_MASK = 2'd0;
  localparam logic [1:0] SEL_PEND = 2'd1;
  localparam logic [1:0] SEL_ISR  = 2'd2;
  localparam logic [1:0] SEL_CMD  = 2'd3;

  // Isolates the lowest set bit (highest priority) as a one-hot value.
  function automatic logic [7:0] lowest_bit(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        idx = i[2:0];
      end
    end
    return idx;
  endfunction

  logic [7:0]  mask_q, mask_d;
  logic [7:0]  pend_q, pend_d;
  logic [7:0]  isr_q, isr_d;
  logic [7:0]  irq_q;
  logic        ack_q;
  logic [15:0] vec_q, vec_d;

  logic [7:0]  pend_eff_s;
  logic [7:0]  allow_s;
  logic [7:0]  elig_s;
  logic        any_elig_s;
  logic [2:0]  win_s;
  logic        ack_fire_s;
  logic [15:0] live_vec_s;
  logic [7:0]  ack_set_s;
  logic [7:0]  pend_clr_s;
  logic [7:0]  eoi_clr_s;
  logic        unused_wdata_s;

  assign unused_wdata_s = ^reg_wdata[15:11];

  // Eligibility, winner selection and acknowledge detection.
  always_comb begin
    pend_eff_s = (pend_q & EDGE_MODE) | (irq & ~EDGE_MODE);
    // lowest_bit(isr)-1 masks indices below the in-service level; wraps to all-ones when isr=0
    allow_s    = lowest_bit(isr_q) - 8'd1;
    elig_s     = pend_eff_s & ~mask_q & allow_s;
    any_elig_s = |elig_s;
    win_s      = lowest_idx(elig_s);
    ack_fire_s = intack & ~ack_q;
    if (any_elig_s) begin
      live_vec_s = {13'd0, win_s};
    end else begin
      live_vec_s = SPURIOUS_VEC;
    end
    if (ack_fire_s && any_elig_s) begin
      ack_set_s = lowest_bit(elig_s);
    end else begin
      ack_set_s = 8'd0;
    end
  end

  // Next-state for mask, pending, in-service and captured vector.
  always_comb begin
    mask_d     = mask_q;
    pend_clr_s = ack_set_s;
    eoi_clr_s  = 8'd0;
    if (reg_wt) begin
      case (reg_sel)
        SEL_MASK: mask_d = reg_wdata[7:0];
        SEL_PEND: pend_clr_s = ack_set_s | reg_wdata[7:0];
        SEL_ISR:  mask_d = mask_q;
        SEL_CMD: begin
          if (reg_wdata[1]) begin
            eoi_clr_s = 8'd1 << reg_wdata[10:8];
          end else if (reg_wdata[0]) begin
            eoi_clr_s = lowest_bit(isr_q);
          end else begin
            eoi_clr_s = 8'd0;
          end
        end
        default: mask_d = mask_q;
      endcase
    end else begin
      mask_d = mask_q;
    end
    // A fresh rising edge beats a same-cycle clear
    pend_d = ((pend_q & ~pend_clr_s) | (irq & ~irq_q)) & EDGE_MODE;
    isr_d  = (isr_q & ~eoi_clr_s) | ack_set_s;
    if (ack_fire_s) begin
      vec_d = live_vec_s;
    end else begin
      vec_d = vec_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= 8'hFF;
      pend_q <= 8'h00;
      isr_q  <= 8'h00;
      irq_q  <= 8'h00;
      ack_q  <= 1'b0;
      vec_q  <= SPURIOUS_VEC;
    end else begin
      mask_q <= mask_d;
      pend_q <= pend_d;
      isr_q  <= isr_d;
      irq_q  <= irq;
      ack_q  <= intack;
      vec_q  <= vec_d;
    end
  end

  // CPU-facing outputs and register read mux.
  always_comb begin
    INT = any_elig_s;
    if (ack_fire_s) begin
      vector = live_vec_s;
    end else begin
      vector = vec_q;
    end
    case (reg_sel)
      SEL_MASK: reg_rdata = {8'd0, mask_q};
      SEL_PEND: reg_rdata = {8'd0, pend_eff_s};
      SEL_ISR:  reg_rdata = {8'd0, isr_q};
      SEL_CMD:  reg_rdata = {12'd0, any_elig_s, win_s};
      default:  reg_rdata = 16'd0;
    endcase
  end

endmodule

// File: tb/tb_pic_controller.sv
// Self-checking bench for pic_controller: directed scenarios with a vector
// scoreboard (expected pushed at stimulus, observed compared after each pulse).
module tb_pic_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq;
  logic        intack;
  logic        INT;
  logic [15:0] vector;
  logic [1:0]  reg_sel;
  logic        reg_wt;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [15:0] d, e, g;

  pic_controller dut (
    .clk(clk), .rst(rst), .irq(irq), .intack(intack), .INT(INT), .vector(vector),
    .reg_sel(reg_sel), .reg_wt(reg_wt), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] s, input logic [15:0] v);
    reg_sel = s; reg_wdata = v; reg_wt = 1'b1;
    tick();
    reg_wt = 1'b0; reg_wdata = 16'd0;
  endtask

  task automatic rd(input logic [1:0] s, output logic [15:0] v);
    reg_sel = s;
    #1;
    v = reg_rdata;
  endtask

  task automatic pulse_irq(input logic [7:0] v);
    irq = v;
    tick();
    irq = 8'd0;
  endtask

  // Hold intack for n cycles, recording the vector seen in each cycle.
  task automatic do_intack(input int n, input logic [7:0] irq_first);
    irq = irq_first;
    intack = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      got_q.push_back(vector);
      @(posedge clk);
      #1;
    end
    intack = 1'b0;
  endtask

  task automatic compare_vectors(input string name);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL %s vector got=%h exp=%h", name, g, e); end
    end
    checks++;
    if (exp_q.size() != got_q.size()) begin
      failures++; $display("FAIL %s sb_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
      exp_q.delete(); got_q.delete();
    end
  endtask

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin failures++; $display("FAIL %s got=%h exp=%h", name, got, exp); end
  endtask

  task automatic test_reset();
    rst = 1'b1; irq = 8'd0; intack = 1'b0; reg_sel = 2'd0; reg_wt = 1'b0; reg_wdata = 16'd0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (INT !== 1'b0) begin failures++; $display("FAIL rst_int got=%b exp=0", INT); end
    checks++;
    if (vector !== 16'h0007) begin failures++; $display("FAIL rst_vec got=%h exp=0007", vector); end
    rd(2'd0, d); check16("rst_mask", d, 16'h00FF);
    rd(2'd1, d); check16("rst_pend", d, 16'h0000);
    rd(2'd2, d); check16("rst_isr", d, 16'h0000);
    rd(2'd3, d); check16("rst_cmd", d, 16'h0000);
  endtask

  task automatic test_basic_ack();
    write_reg(2'd0, 16'h0000);
    pulse_irq(8'h04);
    checks++;
    if (INT !== 1'b1) begin failures++; $display("FAIL t1_int got=%b exp=1", INT); end
    repeat (3) exp_q.push_back(16'h0002);
    do_intack(3, 8'h00);
    compare_vectors("t1");
    tick();
    rd(2'd2, d); check16("t1_isr", d, 16'h0004);
    rd(2'd1, d); check16("t1_pend", d, 16'h0000);
    checks++;
    if (INT !== 1'b0) begin failures++; $display("FAIL t1_int_after got=%b exp=0", INT); end
  endtask

  task automatic test_nesting();
    pulse_irq(8'h20);
    checks++;
    if (INT !== 1'b0) begin failures++; $display("FAIL t2_lowprio_int got=%b exp=0", INT); end
    rd(2'd1, d); check16("t2_pend5", d, 16'h0020);
    pulse_irq(8'h02);
    checks++;
    if (INT !== 1'b1) begin failures++; $display("FAIL t2_hiprio_int got=%b exp=1", INT); end
    exp_q.push_back(16'h0001);
    do_intack(1, 8'h00);
    compare_vectors("t2");
    tick();
    rd(2'd2, d); check16("t2_isr_nest", d, 16'h0006);
    write_reg(2'd3, 16'h0203);
    rd(2'd2, d); check16("t2_spec_eoi", d, 16'h0002);
    write_reg(2'd3, 16'h0001);
    rd(2'd2, d); check16("t2_nonspec_eoi", d, 16'h0000);
    rd(2'd3, d); check16("t2_cmd_read", d, 16'h000D);
    write_reg(2'd1, 16'h0020);
    rd(2'd1, d); check16("t2_w1c", d, 16'h0000);
    checks++;
    if (INT !== 1'b0) begin failures++; $display("FAIL t2_int_w1c got=%b exp=0", INT); end
  endtask

  task automatic test_simul_edges();
    write_reg(2'd0, 16'h0001);
    pulse_irq(8'h09);
    checks++;
    if (INT !== 1'b1) begin failures++; $display("FAIL t3_int got=%b exp=1", INT); end
    exp_q.push_back(16'h0003);
    do_intack(1, 8'h00);
    compare_vectors("t3");
    tick();
    rd(2'd2, d); check16("t3_isr", d, 16'h0008);
    rd(2'd1, d); check16("t3_pend", d, 16'h0001);
    write_reg(2'd1, 16'h00FF);
    write_reg(2'd3, 16'h0001);
    write_reg(2'd0, 16'h0000);
  endtask

  task automatic test_spurious();
    rd(2'd1, d); check16("t4_pend_pre", d, 16'h0000);
    repeat (2) exp_q.push_back(16'h0007);
    do_intack(2, 8'h00);
    compare_vectors("t4");
    tick();
    rd(2'd1, d); check16("t4_pend", d, 16'h0000);
    rd(2'd2, d); check16("t4_isr", d, 16'h0000);
  endtask

  task automatic test_ack_vs_edge();
    pulse_irq(8'h10);
    tick();
    exp_q.push_back(16'h0004);
    do_intack(1, 8'h10);
    irq = 8'h00;
    compare_vectors("t5");
    tick();
    rd(2'd2, d); check16("t5_isr", d, 16'h0010);
    rd(2'd1, d); check16("t5_pend", d, 16'h0010);
    checks++;
    if (INT !== 1'b0) begin failures++; $display("FAIL t5_int got=%b exp=0", INT); end
    write_reg(2'd1, 16'h0010);
    write_reg(2'd3, 16'h0001);
  endtask

  task automatic test_back_to_back();
    pulse_irq(8'h0A);
    exp_q.push_back(16'h0001);
    do_intack(1, 8'h00);
    tick();
    exp_q.push_back(16'h0007);
    do_intack(1, 8'h00);
    tick();
    compare_vectors("b2b_first");
    rd(2'd2, d); check16("b2b_isr", d, 16'h0002);
    rd(2'd1, d); check16("b2b_pend", d, 16'h0008);
    write_reg(2'd3, 16'h0001);
    exp_q.push_back(16'h0003);
    do_intack(1, 8'h00);
    tick();
    compare_vectors("b2b_second");
    rd(2'd2, d); check16("b2b_isr2", d, 16'h0008);
    write_reg(2'd3, 16'h0001);
  endtask

  task automatic test_reset_mid_ack();
    pulse_irq(8'h80);
    exp_q.push_back(16'h0007);
    do_intack(1, 8'h00);
    tick();
    pulse_irq(8'h01);
    exp_q.push_back(16'h0000);
    do_intack(1, 8'h00);
    tick();
    compare_vectors("t6_setup");
    rd(2'd2, d); check16("t6_isr_pre", d, 16'h0081);
    pulse_irq(8'h08);
    intack = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.push_back(16'h0007);
    got_q.push_back(vector);
    compare_vectors("t6_vec");
    checks++;
    if (INT !== 1'b0) begin failures++; $display("FAIL t6_int got=%b exp=0", INT); end
    rd(2'd0, d); check16("t6_mask", d, 16'h00FF);
    rd(2'd1, d); check16("t6_pend", d, 16'h0000);
    rd(2'd2, d); check16("t6_isr", d, 16'h0000);
    intack = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_ack();
    test_nesting();
    test_simul_edges();
    test_spurious();
    test_ack_vs_edge();
    test_back_to_back();
    test_reset_mid_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
